// File: rtl/usb_loopback_ep.sv
// rtl/usb_loopback_ep.sv - single-endpoint OUT-to-IN loopback device logic for the USB transaction interface
module usb_loopback_ep #(
  parameter int EP_NUM = 1,
  parameter int MAXPKT = 64,
  parameter int CW     = 7
) (
  input  logic          clk_4xrate,
  input  logic          rst_sync,
  input  logic          trsac_req,
  input  logic [3:0]    trsac_ep,
  input  logic [1:0]    trsac_type,
  output logic [1:0]    trsac_reply,
  output logic          rfifo_rd,
  input  logic          rfifo_empty,
  input  logic [7:0]    rfifo_rdata,
  output logic          tfifo_wr,
  input  logic          tfifo_full,
  output logic [7:0]    tfifo_wdata,
  output logic [15:0]   ep_enable,
  output logic [15:0]   ep_isoch,
  output logic [15:0]   ep_intnoretry,
  output logic          buf_loaded,
  output logic [CW-1:0] buf_count,
  output logic          ovf
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAXPKT);
  localparam logic [15:0]   EN_MASK  = 16'(1) << EP_NUM;

  localparam logic [1:0] T_OUT    = 2'd0;
  localparam logic [1:0] T_SETUP  = 2'd2;
  localparam logic [1:0] T_RSVD   = 2'd3;
  localparam logic [1:0] R_ACK    = 2'd0;
  localparam logic [1:0] R_NAK    = 2'd1;
  localparam logic [1:0] R_IGNORE = 2'd3;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, FILL} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [MAXPKT];
  logic [CW-1:0] rd_ptr, rd_ptr_n, count_n;
  logic [1:0]    reply_n;
  logic [7:0]    wdata_n;
  logic          rd_n, wr_n, loaded_n, ovf_n, mem_we, ep_hit;

  assign ep_hit        = (trsac_ep == 4'(EP_NUM));
  assign ep_isoch      = '0;
  assign ep_intnoretry = '0;

  // rfifo_rd is a register, so a pop issued this cycle only shows up in
  // rfifo_empty next cycle; pops therefore alternate with re-checks of empty.
  always_comb begin
    state_n  = state;
    reply_n  = trsac_reply;
    rd_n     = 1'b0;
    wr_n     = 1'b0;
    wdata_n  = tfifo_wdata;
    rd_ptr_n = rd_ptr;
    count_n  = buf_count;
    loaded_n = buf_loaded;
    ovf_n    = ovf;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (trsac_req) begin
          if (!ep_hit || trsac_type == T_RSVD) begin
            reply_n = R_IGNORE;
          end else if (trsac_type == T_OUT) begin
            if (buf_loaded) begin
              reply_n = R_NAK;
              state_n = FLUSH;
            end else begin
              reply_n = R_ACK;
              state_n = DRAIN;
            end
          end else if (trsac_type == T_SETUP) begin
            reply_n  = R_ACK;
            count_n  = '0;
            rd_ptr_n = '0;
            loaded_n = 1'b0;
            ovf_n    = 1'b0;
            state_n  = FLUSH;
          end else if (buf_loaded) begin
            reply_n = R_ACK;
            state_n = FILL;
          end else begin
            reply_n = R_NAK;
          end
        end
      end
      DRAIN: begin
        if (rfifo_rd) begin
          if (buf_count < FULL_CNT) begin
            mem_we  = 1'b1;
            count_n = buf_count + 1'b1;
          end else begin
            ovf_n = 1'b1;
          end
        end else if (!rfifo_empty) begin
          rd_n = 1'b1;
        end else begin
          loaded_n = 1'b1;
          state_n  = IDLE;
        end
      end
      FLUSH: begin
        if (!rfifo_rd) begin
          if (!rfifo_empty) rd_n = 1'b1;
          else state_n = IDLE;
        end
      end
      FILL: begin
        if (rd_ptr == buf_count) begin
          loaded_n = 1'b0;
          count_n  = '0;
          rd_ptr_n = '0;
          state_n  = IDLE;
        end else if (!tfifo_full) begin
          wr_n     = 1'b1;
          wdata_n  = mem[rd_ptr[AW-1:0]];
          rd_ptr_n = rd_ptr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (trsac_req && state != IDLE) reply_n = R_NAK;
  end

  always_ff @(posedge clk_4xrate) begin
    if (rst_sync) begin
      state       <= IDLE;
      trsac_reply <= R_IGNORE;
      rfifo_rd    <= 1'b0;
      tfifo_wr    <= 1'b0;
      tfifo_wdata <= 8'h00;
      rd_ptr      <= '0;
      buf_count   <= '0;
      buf_loaded  <= 1'b0;
      ovf         <= 1'b0;
      ep_enable   <= '0;
    end else begin
      state       <= state_n;
      trsac_reply <= reply_n;
      rfifo_rd    <= rd_n;
      tfifo_wr    <= wr_n;
      tfifo_wdata <= wdata_n;
      rd_ptr      <= rd_ptr_n;
      buf_count   <= count_n;
      buf_loaded  <= loaded_n;
      ovf         <= ovf_n;
      ep_enable   <= EN_MASK;
    end
  end

  // Packet storage carries no reset; buf_count alone defines valid content.
  always_ff @(posedge clk_4xrate) begin
    if (mem_we && !rst_sync) mem[buf_count[AW-1:0]] <= rfifo_rdata;
  end

endmodule

// File: tb/tb_usb_loopback_ep.sv
// tb/tb_usb_loopback_ep.sv - self-checking bench for usb_loopback_ep
module tb_usb_loopback_ep;

  localparam logic [1:0] OUT = 2'd0, IN = 2'd1, SETUP = 2'd2, RSVD = 2'd3;
  localparam logic [1:0] ACK = 2'd0, NAK = 2'd1, IGN = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trsac_req = 1'b0;
  logic [3:0]  trsac_ep = 4'd0;
  logic [1:0]  trsac_type = 2'd0;
  logic [1:0]  trsac_reply;
  logic        rfifo_rd;
  logic        rfifo_empty = 1'b1;
  logic [7:0]  rfifo_rdata = 8'h00;
  logic        tfifo_wr;
  logic        tfifo_full = 1'b0;
  logic [7:0]  tfifo_wdata;
  logic [15:0] ep_enable, ep_isoch, ep_intnoretry;
  logic        buf_loaded;
  logic [6:0]  buf_count;
  logic        ovf;

  usb_loopback_ep dut (
    .clk_4xrate(clk), .rst_sync(rst), .trsac_req(trsac_req), .trsac_ep(trsac_ep),
    .trsac_type(trsac_type), .trsac_reply(trsac_reply), .rfifo_rd(rfifo_rd),
    .rfifo_empty(rfifo_empty), .rfifo_rdata(rfifo_rdata), .tfifo_wr(tfifo_wr),
    .tfifo_full(tfifo_full), .tfifo_wdata(tfifo_wdata), .ep_enable(ep_enable),
    .ep_isoch(ep_isoch), .ep_intnoretry(ep_intnoretry), .buf_loaded(buf_loaded),
    .buf_count(buf_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int rd_cnt = 0, wr_cnt = 0;
  logic [7:0] rq[$];
  logic [7:0] exp_q[$];
  logic [7:0] mbuf[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endfunction

  function automatic void rf_update();
    rfifo_empty = (rq.size() == 0);
    rfifo_rdata = (rq.size() == 0) ? 8'h00 : rq[0];
  endfunction

  // FIFO models: pops/pushes take effect at the clock edge where the DUT strobe is high.
  logic       pop_s, push_s, full_s, full_prev = 1'b0;
  logic [7:0] wd_s;
  always @(posedge clk) begin
    pop_s = rfifo_rd; push_s = tfifo_wr; wd_s = tfifo_wdata; full_s = tfifo_full;
    #1;
    if (pop_s) begin
      chk("rfifo_pop_nonempty", rq.size() > 0, 1);
      if (rq.size() > 0) void'(rq.pop_front());
      rd_cnt++;
    end
    if (push_s) begin
      wr_cnt++;
      chk("wr_after_full", full_prev, 0);
      if (exp_q.size() == 0) chk("tx_unexpected", wd_s, 32'hFFFF);
      else chk("tx_byte", wd_s, exp_q.pop_front());
    end
    full_prev = full_s;
    rf_update();
  end

  logic toggle_en = 1'b0;
  int   tcnt = 0;
  always @(negedge clk) begin
    if (toggle_en) begin
      tcnt++;
      if (tcnt % 3 == 0) tfifo_full = ~tfifo_full;
    end else begin
      tcnt = 0;
      tfifo_full = 1'b0;
    end
  end

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) rq.push_back(8'(base + i));
    rf_update();
  endtask

  task automatic do_req(input logic [3:0] ep, input logic [1:0] typ, output logic [1:0] rep);
    @(negedge clk);
    trsac_req = 1'b1; trsac_ep = ep; trsac_type = typ;
    @(negedge clk);
    trsac_req = 1'b0;
    rep = trsac_reply;
  endtask

  task automatic settle();
    int guard = 0;
    repeat (2) @(negedge clk);
    while ((rq.size() != 0 || exp_q.size() != 0 || rfifo_rd || tfifo_wr) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk("settle_timeout", guard >= 600, 0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] ep;
    logic [1:0] typ;
    int         nbytes;
    logic [7:0] base;
    logic [1:0] reply;
    logic       loaded;
    int         count;
    logic       ovf;
  } vec_t;

  vec_t vecs[14];
  logic [1:0] rep;
  int r0, w0, guard;

  initial begin
    vecs[0]  = '{4'd2, OUT,   0, 8'h00, IGN, 1'b0,  0, 1'b0};
    vecs[1]  = '{4'd1, RSVD,  0, 8'h00, IGN, 1'b0,  0, 1'b0};
    vecs[2]  = '{4'd1, IN,    0, 8'h00, NAK, 1'b0,  0, 1'b0};
    vecs[3]  = '{4'd1, OUT,   8, 8'h01, ACK, 1'b1,  8, 1'b0};
    vecs[4]  = '{4'd1, OUT,   5, 8'hC0, NAK, 1'b1,  8, 1'b0};
    vecs[5]  = '{4'd1, IN,    0, 8'h00, ACK, 1'b0,  0, 1'b0};
    vecs[6]  = '{4'd1, OUT,   0, 8'h00, ACK, 1'b1,  0, 1'b0};
    vecs[7]  = '{4'd1, IN,    0, 8'h00, ACK, 1'b0,  0, 1'b0};
    vecs[8]  = '{4'd1, OUT,   3, 8'h30, ACK, 1'b1,  3, 1'b0};
    vecs[9]  = '{4'd1, SETUP, 8, 8'h50, ACK, 1'b0,  0, 1'b0};
    vecs[10] = '{4'd1, IN,    0, 8'h00, NAK, 1'b0,  0, 1'b0};
    vecs[11] = '{4'd1, OUT,  70, 8'h40, ACK, 1'b1, 64, 1'b1};
    vecs[12] = '{4'd1, IN,    0, 8'h00, ACK, 1'b0,  0, 1'b1};
    vecs[13] = '{4'd1, SETUP, 0, 8'h00, ACK, 1'b0,  0, 1'b0};

    rf_update();
    repeat (3) @(negedge clk);
    chk("rst_reply", trsac_reply, IGN);
    chk("rst_rfifo_rd", rfifo_rd, 0);
    chk("rst_tfifo_wr", tfifo_wr, 0);
    chk("rst_wdata", tfifo_wdata, 0);
    chk("rst_ep_enable", ep_enable, 0);
    chk("rst_loaded", buf_loaded, 0);
    chk("rst_count", buf_count, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ep_enable", ep_enable, 16'h0002);
    chk("ep_isoch", ep_isoch, 0);
    chk("ep_intnoretry", ep_intnoretry, 0);

    for (int i = 0; i < 14; i++) begin
      load(vecs[i].nbytes, vecs[i].base);
      if (vecs[i].typ == IN && vecs[i].reply == ACK)
        foreach (mbuf[j]) exp_q.push_back(mbuf[j]);
      r0 = rd_cnt;
      do_req(vecs[i].ep, vecs[i].typ, rep);
      chk($sformatf("v%0d_reply", i), rep, vecs[i].reply);
      settle();
      chk($sformatf("v%0d_reply_held", i), trsac_reply, vecs[i].reply);
      chk($sformatf("v%0d_loaded", i), buf_loaded, vecs[i].loaded);
      chk($sformatf("v%0d_count", i), buf_count, vecs[i].count);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("v%0d_rd_pops", i), rd_cnt - r0,
          (vecs[i].typ != IN && vecs[i].reply != IGN) ? vecs[i].nbytes : 0);
      if (vecs[i].reply == ACK) begin
        if (vecs[i].typ != OUT) mbuf.delete();
        else begin
          mbuf.delete();
          for (int j = 0; j < vecs[i].nbytes && j < 64; j++) mbuf.push_back(8'(vecs[i].base + j));
        end
      end
    end

    // IN with tfifo_full toggling every 3 cycles
    load(20, 8'hA0);
    do_req(4'd1, OUT, rep);
    chk("tog_out_reply", rep, ACK);
    settle();
    for (int j = 0; j < 20; j++) exp_q.push_back(8'(8'hA0 + j));
    w0 = wr_cnt;
    toggle_en = 1'b1;
    do_req(4'd1, IN, rep);
    chk("tog_in_reply", rep, ACK);
    settle();
    toggle_en = 1'b0;
    chk("tog_wr_count", wr_cnt - w0, 20);
    chk("tog_loaded", buf_loaded, 0);

    // request arriving while DRAIN is busy
    load(30, 8'h10);
    do_req(4'd1, OUT, rep);
    chk("busy_out_reply", rep, ACK);
    repeat (6) @(negedge clk);
    do_req(4'd1, IN, rep);
    chk("busy_in_reply", rep, NAK);
    settle();
    chk("busy_loaded", buf_loaded, 1);
    chk("busy_count", buf_count, 30);
    for (int j = 0; j < 30; j++) exp_q.push_back(8'(8'h10 + j));
    do_req(4'd1, IN, rep);
    chk("busy_in2_reply", rep, ACK);
    settle();
    chk("busy_in2_loaded", buf_loaded, 0);

    // reset during FILL after the fourth byte
    load(8, 8'h01);
    do_req(4'd1, OUT, rep);
    settle();
    for (int j = 0; j < 8; j++) exp_q.push_back(8'(8'h01 + j));
    w0 = wr_cnt;
    do_req(4'd1, IN, rep);
    chk("mid_in_reply", rep, ACK);
    guard = 0;
    while (wr_cnt - w0 < 4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_wait_timeout", guard >= 100, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr", tfifo_wr, 0);
    chk("mid_rst_rd", rfifo_rd, 0);
    chk("mid_rst_reply", trsac_reply, IGN);
    chk("mid_rst_loaded", buf_loaded, 0);
    chk("mid_rst_count", buf_count, 0);
    chk("mid_rst_wdata", tfifo_wdata, 0);
    chk("mid_rst_ep_enable", ep_enable, 0);
    rst = 1'b0;
    exp_q.delete();
    w0 = wr_cnt;
    repeat (2) @(negedge clk);
    chk("post_rst_ep_enable", ep_enable, 16'h0002);
    do_req(4'd1, IN, rep);
    chk("post_rst_in_reply", rep, NAK);
    settle();
    chk("post_rst_no_wr", wr_cnt - w0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
